// File: rtl/wb_pkg.sv
// wb_pkg: shared defaults and types for the register-file write-back unit.
package wb_pkg;

  // Default register index and data widths
  localparam int WB_ADDRESS_WIDTH = 5;
  localparam int WB_DATA_WIDTH    = 32;

  // Index of the hard-wired zero register; writes to it are suppressed
  localparam int unsigned REG_ZERO = 0;

  // One pending write: destination register and its value
  typedef struct packed {
    logic [WB_ADDRESS_WIDTH-1:0] rd;
    logic [WB_DATA_WIDTH-1:0]    data;
  } wb_entry_t;

endpackage

// File: rtl/wb_unit_if.sv
// wb_unit_if: ALU/load/register-file/decode signals of the write-back unit.
// Optional forwarding ports exist only when WB_FORWARD_EN is defined.
interface wb_unit_if
  import wb_pkg::*;
#(
  parameter int ADDRESS_WIDTH = WB_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = WB_DATA_WIDTH
) ();

  logic                     alu_valid;
  logic                     alu_ready;
  logic [ADDRESS_WIDTH-1:0] alu_rd;
  logic [DATA_WIDTH-1:0]    alu_data;
  logic                     ld_issue;
  logic                     ld_issue_ready;
  logic [ADDRESS_WIDTH-1:0] ld_issue_rd;
  logic                     ld_resp_valid;
  logic [DATA_WIDTH-1:0]    ld_resp_data;
  logic                     we3;
  logic [ADDRESS_WIDTH-1:0] ad3;
  logic [DATA_WIDTH-1:0]    wd3;
  logic [ADDRESS_WIDTH-1:0] ad1;
  logic [ADDRESS_WIDTH-1:0] ad2;
  logic                     busy1;
  logic                     busy2;
  logic                     err;
`ifdef WB_FORWARD_EN
  logic                     fwd1_valid;
  logic                     fwd2_valid;
  logic [DATA_WIDTH-1:0]    fwd1_data;
  logic [DATA_WIDTH-1:0]    fwd2_data;
`endif

  // Pipeline side: offers results and load traffic, observes the write port
  modport master (
    output alu_valid, alu_rd, alu_data, ld_issue, ld_issue_rd, ld_resp_valid, ld_resp_data, ad1, ad2,
`ifdef WB_FORWARD_EN
    input  fwd1_valid, fwd2_valid, fwd1_data, fwd2_data,
`endif
    input  alu_ready, ld_issue_ready, we3, ad3, wd3, busy1, busy2, err
  );

  // Write-back unit side
  modport slave (
    input  alu_valid, alu_rd, alu_data, ld_issue, ld_issue_rd, ld_resp_valid, ld_resp_data, ad1, ad2,
`ifdef WB_FORWARD_EN
    output fwd1_valid, fwd2_valid, fwd1_data, fwd2_data,
`endif
    output alu_ready, ld_issue_ready, we3, ad3, wd3, busy1, busy2, err
  );

endinterface

// File: rtl/wb_tag_fifo.sv
// wb_tag_fifo: in-order FIFO of destination register indices for outstanding
// loads, with per-entry match vectors against two decode read addresses.
module wb_tag_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = WB_ADDRESS_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [AW-1:0]    push_rd,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [AW-1:0]    head,
  input  logic [AW-1:0]    q1,
  input  logic [AW-1:0]    q2,
  output logic [DEPTH-1:0] match1,
  output logic [DEPTH-1:0] match2
);

  localparam int PW = $clog2(DEPTH);

  logic [AW-1:0]    mem_r [DEPTH];
  logic [DEPTH-1:0] vld_r;
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic             push_ok_s;
  logic             pop_ok_s;
  logic [DEPTH-1:0] vld_next_s;

  assign full  = &vld_r;
  assign empty = ~|vld_r;
  assign head  = mem_r[rd_ptr_r];

  // Guard push/pop against full/empty and compute next per-slot valid bits
  always_comb begin
    push_ok_s  = push && !full;
    pop_ok_s   = pop && !empty;
    vld_next_s = (vld_r & ~(DEPTH'(pop_ok_s) << rd_ptr_r)) | (DEPTH'(push_ok_s) << wr_ptr_r);
  end

  // Per-entry match of valid tags against both query addresses
  always_comb begin
    match1 = '0;
    match2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match1[i] = vld_r[i] && (mem_r[i] == q1);
      match2[i] = vld_r[i] && (mem_r[i] == q2);
    end
  end

  // Storage, pointers and valid bits
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_r    <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      vld_r <= vld_next_s;
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_rd;
        wr_ptr_r        <= wr_ptr_r + PW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
    end
  end

endmodule

// File: rtl/wb_unit.sv
// wb_unit: single writer of the register-file write port. Merges buffered ALU
// results with in-order load returns (loads win), tracks pending destinations
// for decode hazard stalls, and flags responses with no outstanding load.
// Optional feature macro: WB_FORWARD_EN (forward the write register to decode).
module wb_unit
  import wb_pkg::*;
#(
  parameter int ADDRESS_WIDTH = WB_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = WB_DATA_WIDTH,
  parameter int LD_DEPTH      = 4
) (
  input logic      clk,
  input logic      rst,
  wb_unit_if.slave bus
);

  localparam logic [ADDRESS_WIDTH-1:0] ZERO_RD = ADDRESS_WIDTH'(REG_ZERO);

  // Two-entry ALU result buffer
  logic [1:0]               alu_vld_r;
  logic [ADDRESS_WIDTH-1:0] alu_rd_r   [2];
  logic [DATA_WIDTH-1:0]    alu_data_r [2];
  logic                     alu_wr_ptr_r;
  logic                     alu_rd_ptr_r;
  logic [1:0]               alu_vld_next_s;

  // Write port and error flag
  logic                     we3_r;
  logic [ADDRESS_WIDTH-1:0] ad3_r;
  logic [DATA_WIDTH-1:0]    wd3_r;
  logic                     err_r;

  // Tag FIFO view
  logic                     tag_full_s;
  logic                     tag_empty_s;
  logic [ADDRESS_WIDTH-1:0] tag_head_s;
  logic [LD_DEPTH-1:0]      tag_m1_s;
  logic [LD_DEPTH-1:0]      tag_m2_s;

  // Per-cycle decisions
  logic                     alu_enq_s;
  logic                     alu_deq_s;
  logic                     tag_push_s;
  logic                     ld_win_s;
  logic                     resp_orphan_s;
  logic                     alu_m1_s;
  logic                     alu_m2_s;
  logic                     wr_m1_s;
  logic                     wr_m2_s;

  wb_tag_fifo #(
    .DEPTH (LD_DEPTH),
    .AW    (ADDRESS_WIDTH)
  ) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (tag_push_s),
    .push_rd (bus.ld_issue_rd),
    .pop     (ld_win_s),
    .full    (tag_full_s),
    .empty   (tag_empty_s),
    .head    (tag_head_s),
    .q1      (bus.ad1),
    .q2      (bus.ad2),
    .match1  (tag_m1_s),
    .match2  (tag_m2_s)
  );

  // Handshakes and write-port arbitration; a load response always beats the ALU
  always_comb begin
    alu_enq_s      = bus.alu_valid && !(&alu_vld_r) && (bus.alu_rd != ZERO_RD);
    tag_push_s     = bus.ld_issue && !tag_full_s;
    ld_win_s       = bus.ld_resp_valid && !tag_empty_s;
    resp_orphan_s  = bus.ld_resp_valid && tag_empty_s;
    alu_deq_s      = !ld_win_s && (|alu_vld_r);
    alu_vld_next_s = (alu_vld_r & ~(2'(alu_deq_s) << alu_rd_ptr_r)) | (2'(alu_enq_s) << alu_wr_ptr_r);
  end

  // ALU buffer storage and pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_vld_r    <= 2'b00;
      alu_wr_ptr_r <= 1'b0;
      alu_rd_ptr_r <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        alu_rd_r[i]   <= '0;
        alu_data_r[i] <= '0;
      end
    end else begin
      alu_vld_r <= alu_vld_next_s;
      if (alu_enq_s) begin
        alu_rd_r[alu_wr_ptr_r]   <= bus.alu_rd;
        alu_data_r[alu_wr_ptr_r] <= bus.alu_data;
        alu_wr_ptr_r             <= ~alu_wr_ptr_r;
      end
      if (alu_deq_s) begin
        alu_rd_ptr_r <= ~alu_rd_ptr_r;
      end
    end
  end

  // Write-port register: load return first, then ALU buffer head, else idle
  always_ff @(posedge clk) begin
    if (rst) begin
      we3_r <= 1'b0;
      ad3_r <= '0;
      wd3_r <= '0;
    end else if (ld_win_s) begin
      we3_r <= (tag_head_s != ZERO_RD);
      ad3_r <= tag_head_s;
      wd3_r <= bus.ld_resp_data;
    end else if (alu_deq_s) begin
      we3_r <= 1'b1;
      ad3_r <= alu_rd_r[alu_rd_ptr_r];
      wd3_r <= alu_data_r[alu_rd_ptr_r];
    end else begin
      we3_r <= 1'b0;
    end
  end

  // Sticky flag for a load response arriving with nothing outstanding
  always_ff @(posedge clk) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if (resp_orphan_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  // Pending-write lookups for both decode read addresses
  always_comb begin
    alu_m1_s = 1'b0;
    alu_m2_s = 1'b0;
    for (int i = 0; i < 2; i++) begin
      alu_m1_s = alu_m1_s | (alu_vld_r[i] && (alu_rd_r[i] == bus.ad1));
      alu_m2_s = alu_m2_s | (alu_vld_r[i] && (alu_rd_r[i] == bus.ad2));
    end
    wr_m1_s = we3_r && (ad3_r == bus.ad1);
    wr_m2_s = we3_r && (ad3_r == bus.ad2);
  end

  assign bus.we3            = we3_r;
  assign bus.ad3            = ad3_r;
  assign bus.wd3            = wd3_r;
  assign bus.err            = err_r;
  assign bus.alu_ready      = !(&alu_vld_r);
  assign bus.ld_issue_ready = !tag_full_s;

`ifdef WB_FORWARD_EN
  // The register being written is forwarded, so it no longer stalls decode
  assign bus.busy1      = (bus.ad1 != ZERO_RD) && ((|tag_m1_s) || alu_m1_s);
  assign bus.busy2      = (bus.ad2 != ZERO_RD) && ((|tag_m2_s) || alu_m2_s);
  assign bus.fwd1_valid = wr_m1_s && (bus.ad1 != ZERO_RD);
  assign bus.fwd2_valid = wr_m2_s && (bus.ad2 != ZERO_RD);
  assign bus.fwd1_data  = wd3_r;
  assign bus.fwd2_data  = wd3_r;
`else
  assign bus.busy1 = (bus.ad1 != ZERO_RD) && ((|tag_m1_s) || alu_m1_s || wr_m1_s);
  assign bus.busy2 = (bus.ad2 != ZERO_RD) && ((|tag_m2_s) || alu_m2_s || wr_m2_s);
`endif

endmodule
